// File: rtl/match_controller_if.sv
// rtl/match_controller_if.sv - control inputs and status outputs of the match sequencer
interface match_controller_if #(
    parameter int SCORE_W = 4,
    parameter int CNT_W   = 2
);
    logic               start;
    logic               pause;
    logic               tick;
    logic               goal_left;
    logic               goal_right;
    logic               time_over;
    logic               timer_run;
    logic               timer_reload;
    logic               freeze;
    logic               respawn;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [2:0]         state;
    logic [CNT_W-1:0]   countdown;
    logic [1:0]         winner;

    modport master (
        output start, pause, tick, goal_left, goal_right, time_over,
        input  timer_run, timer_reload, freeze, respawn,
        input  score_left, score_right, state, countdown, winner
    );

    modport slave (
        input  start, pause, tick, goal_left, goal_right, time_over,
        output timer_run, timer_reload, freeze, respawn,
        output score_left, score_right, state, countdown, winner
    );
endinterface

// File: rtl/match_controller.sv
// rtl/match_controller.sv - game sequencer: kickoff countdown, play, goal pause, pause, game over
module match_controller #(
    parameter int KICKOFF_TICKS = 3,
    parameter int PAUSE_TICKS   = 2,
    parameter int MAX_SCORE     = 9,
    parameter int SCORE_W       = 4,
    parameter int CNT_W         = 2
) (
    input  logic              clk25,
    input  logic              reset_n,
    match_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        KICKOFF    = 3'd1,
        PLAY       = 3'd2,
        GOAL_PAUSE = 3'd3,
        PAUSED     = 3'd4,
        GAME_OVER  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]   KICK_LOAD  = CNT_W'(KICKOFF_TICKS);
    localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SCORE_W-1:0] left_q, left_n, right_q, right_n;
    logic [SCORE_W-1:0] left_inc, right_inc;
    logic [1:0]         win_q, win_n;
    logic               start_q, pause_q;
    logic               start_rise, pause_rise;
    logic               reload_q, reload_n, respawn_q, respawn_n;
    logic               run_q, freeze_q;
    logic [CNT_W-1:0]   countdown_q;

    function automatic logic [1:0] decide(input logic [SCORE_W-1:0] l, input logic [SCORE_W-1:0] r);
        if (l > r)      return 2'b01;
        else if (r > l) return 2'b10;
        else            return 2'b11;
    endfunction

    // Edge history resets to 1 so a button held through reset cannot fire.
    assign start_rise = bus.start & ~start_q;
    assign pause_rise = bus.pause & ~pause_q;

    assign left_inc  = (bus.goal_left  && left_q  != SCORE_MAX) ? left_q  + 1'b1 : left_q;
    assign right_inc = (bus.goal_right && right_q != SCORE_MAX) ? right_q + 1'b1 : right_q;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        left_n    = left_q;
        right_n   = right_q;
        win_n     = win_q;
        reload_n  = 1'b0;
        respawn_n = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    state_n   = KICKOFF;
                    cnt_n     = KICK_LOAD;
                    left_n    = '0;
                    right_n   = '0;
                    win_n     = 2'b00;
                    reload_n  = 1'b1;
                    respawn_n = 1'b1;
                end
            end
            KICKOFF: begin
                if (bus.tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
            end
            PLAY: begin
                if (bus.goal_left || bus.goal_right) begin
                    left_n  = left_inc;
                    right_n = right_inc;
                    if (left_inc == SCORE_MAX || right_inc == SCORE_MAX || bus.time_over) begin
                        state_n = GAME_OVER;
                        win_n   = decide(left_inc, right_inc);
                    end else begin
                        state_n = GOAL_PAUSE;
                        cnt_n   = PAUSE_LOAD;
                    end
                end else if (bus.time_over) begin
                    state_n = GAME_OVER;
                    win_n   = decide(left_q, right_q);
                end else if (pause_rise) begin
                    state_n = PAUSED;
                end
            end
            GOAL_PAUSE: begin
                if (bus.time_over) begin
                    state_n = GAME_OVER;
                    win_n   = decide(left_q, right_q);
                end else if (bus.tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_n   = KICKOFF;
                        cnt_n     = KICK_LOAD;
                        respawn_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
            end
            PAUSED: begin
                // Abort wins over resume when both buttons rise together.
                if (start_rise)      state_n = IDLE;
                else if (pause_rise) state_n = PLAY;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                left_n  = '0;
                right_n = '0;
                win_n   = 2'b00;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            win_q       <= 2'b00;
            start_q     <= 1'b1;
            pause_q     <= 1'b1;
            reload_q    <= 1'b0;
            respawn_q   <= 1'b0;
            run_q       <= 1'b0;
            freeze_q    <= 1'b1;
            countdown_q <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            left_q      <= left_n;
            right_q     <= right_n;
            win_q       <= win_n;
            start_q     <= bus.start;
            pause_q     <= bus.pause;
            reload_q    <= reload_n;
            respawn_q   <= respawn_n;
            run_q       <= (state_n == PLAY);
            freeze_q    <= (state_n != PLAY);
            countdown_q <= (state_n == KICKOFF) ? cnt_n : '0;
        end
    end

    assign bus.state        = state_q;
    assign bus.score_left   = left_q;
    assign bus.score_right  = right_q;
    assign bus.winner       = win_q;
    assign bus.timer_run    = run_q;
    assign bus.freeze       = freeze_q;
    assign bus.timer_reload = reload_q;
    assign bus.respawn      = respawn_q;
    assign bus.countdown    = countdown_q;
endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - vector table and scoreboard bench for match_controller
module tb_match_controller;
    localparam int ID = 0, KO = 1, PL = 2, GP = 3, PA = 4, GO = 5;
    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] S  = 6'b100000;
    localparam logic [5:0] P  = 6'b010000;
    localparam logic [5:0] T  = 6'b001000;
    localparam logic [5:0] GL = 6'b000100;
    localparam logic [5:0] GR = 6'b000010;
    localparam logic [5:0] TO = 6'b000001;

    typedef struct {
        logic [5:0] in;
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       rld;
        logic       rsp;
        logic [1:0] cd;
        logic [1:0] win;
    } vec_t;

    logic clk25 = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   ml = 0;
    int   mr = 0;
    vec_t tbl[$];
    vec_t sb[$];
    vec_t e;

    match_controller_if #(.SCORE_W(4), .CNT_W(2)) bus ();

    match_controller #(
        .KICKOFF_TICKS(3), .PAUSE_TICKS(2), .MAX_SCORE(9), .SCORE_W(4), .CNT_W(2)
    ) dut (
        .clk25  (clk25),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #20 clk25 = ~clk25;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] in, input int st, input int sl, input int sr,
                       input int rld, input int rsp, input int cd, input int win);
        vec_t v;
        v.in  = in;
        v.st  = 3'(st);
        v.sl  = 4'(sl);
        v.sr  = 4'(sr);
        v.rld = 1'(rld);
        v.rsp = 1'(rsp);
        v.cd  = 2'(cd);
        v.win = 2'(win);
        tbl.push_back(v);
    endtask

    task automatic add_kick_to_play();
        add(T, KO, ml, mr, 0, 0, 2, 0);
        add(T, KO, ml, mr, 0, 0, 1, 0);
        add(T, PL, ml, mr, 0, 0, 0, 0);
    endtask

    task automatic add_start();
        ml = 0;
        mr = 0;
        add(S, KO, 0, 0, 1, 1, 3, 0);
    endtask

    // One goal from PLAY that does not end the match, back through pause and kickoff.
    task automatic add_goal_round(input int l, input int r);
        ml += l;
        mr += r;
        add((l != 0 ? GL : N) | (r != 0 ? GR : N), GP, ml, mr, 0, 0, 0, 0);
        add(T, GP, ml, mr, 0, 0, 0, 0);
        add(T, KO, ml, mr, 0, 1, 3, 0);
        add_kick_to_play();
    endtask

    task automatic check_outputs(input string tag, input vec_t x);
        chk({tag, ".state"},   int'(bus.state),        int'(x.st));
        chk({tag, ".sl"},      int'(bus.score_left),   int'(x.sl));
        chk({tag, ".sr"},      int'(bus.score_right),  int'(x.sr));
        chk({tag, ".run"},     int'(bus.timer_run),    (x.st == 3'(PL)) ? 1 : 0);
        chk({tag, ".freeze"},  int'(bus.freeze),       (x.st == 3'(PL)) ? 0 : 1);
        chk({tag, ".reload"},  int'(bus.timer_reload), int'(x.rld));
        chk({tag, ".respawn"}, int'(bus.respawn),      int'(x.rsp));
        chk({tag, ".cd"},      int'(bus.countdown),    int'(x.cd));
        chk({tag, ".win"},     int'(bus.winner),       int'(x.win));
    endtask

    initial begin
        vec_t rst_v;
        rst_v.in = N; rst_v.st = 3'(ID); rst_v.sl = 0; rst_v.sr = 0;
        rst_v.rld = 0; rst_v.rsp = 0; rst_v.cd = 0; rst_v.win = 0;

        // start held through reset must not trigger
        add(S, ID, 0, 0, 0, 0, 0, 0);
        add(N, ID, 0, 0, 0, 0, 0, 0);
        add(S, KO, 0, 0, 1, 1, 3, 0);
        add(S, KO, 0, 0, 0, 0, 3, 0);
        add(S | T, KO, 0, 0, 0, 0, 2, 0);
        add(T, KO, 0, 0, 0, 0, 1, 0);
        add(P, KO, 0, 0, 0, 0, 1, 0);
        add(T, PL, 0, 0, 0, 0, 0, 0);
        add(GL, GP, 1, 0, 0, 0, 0, 0);
        add(GL, GP, 1, 0, 0, 0, 0, 0);
        add(T, GP, 1, 0, 0, 0, 0, 0);
        add(T, KO, 1, 0, 0, 1, 3, 0);
        ml = 1; mr = 0;
        add_kick_to_play();
        add(P, PA, 1, 0, 0, 0, 0, 0);
        add(P | T | GL, PA, 1, 0, 0, 0, 0, 0);
        add(N, PA, 1, 0, 0, 0, 0, 0);
        add(P, PL, 1, 0, 0, 0, 0, 0);
        add(GR, GP, 1, 1, 0, 0, 0, 0);
        add(S, GP, 1, 1, 0, 0, 0, 0);
        add(T, GP, 1, 1, 0, 0, 0, 0);
        add(TO, GO, 1, 1, 0, 0, 0, 3);
        add(GL, GO, 1, 1, 0, 0, 0, 3);
        add_start();
        add_kick_to_play();
        // 3-3 then simultaneous goals, time over during the goal pause
        for (int i = 0; i < 3; i++) add_goal_round(1, 1);
        add(GL | GR, GP, 4, 4, 0, 0, 0, 0);
        add(TO, GO, 4, 4, 0, 0, 0, 3);
        add(N, GO, 4, 4, 0, 0, 0, 3);
        add_start();
        add_kick_to_play();
        // 8-0 then the ninth goal ends the match at once
        for (int i = 0; i < 8; i++) add_goal_round(1, 0);
        add(GL, GO, 9, 0, 0, 0, 0, 1);
        add(GL | GR, GO, 9, 0, 0, 0, 0, 1);
        add(GR | T, GO, 9, 0, 0, 0, 0, 1);
        add_start();
        add_kick_to_play();
        add_goal_round(1, 0);
        add(P, PA, 1, 0, 0, 0, 0, 0);
        add(N, PA, 1, 0, 0, 0, 0, 0);
        add(S, ID, 1, 0, 0, 0, 0, 0);
        add(N, ID, 1, 0, 0, 0, 0, 0);
        add_start();
        add_kick_to_play();
        add(TO, GO, 0, 0, 0, 0, 0, 3);
        add(N, GO, 0, 0, 0, 0, 0, 3);
        add_start();
        add_kick_to_play();
        add_goal_round(0, 1);
        add(TO, GO, 0, 1, 0, 0, 0, 2);

        {bus.start, bus.pause, bus.tick, bus.goal_left, bus.goal_right, bus.time_over} = S;
        repeat (3) @(negedge clk25);
        check_outputs("reset", rst_v);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            {bus.start, bus.pause, bus.tick, bus.goal_left, bus.goal_right, bus.time_over} = tbl[i].in;
            sb.push_back(tbl[i]);
            @(negedge clk25);
            e = sb.pop_front();
            check_outputs($sformatf("v%0d", i), e);
        end
        chk("sb_empty", sb.size(), 0);

        // Asynchronous reset in GAME_OVER with right-side win, start held high
        {bus.start, bus.pause, bus.tick, bus.goal_left, bus.goal_right, bus.time_over} = S;
        #5 reset_n = 1'b0;
        #1 check_outputs("async_rst", rst_v);
        @(negedge clk25);
        check_outputs("rst_hold", rst_v);
        reset_n = 1'b1;
        @(negedge clk25);
        check_outputs("rst_release", rst_v);
        bus.start = 1'b0;
        @(negedge clk25);
        bus.start = 1'b1;
        @(negedge clk25);
        chk("restart.state",  int'(bus.state),        KO);
        chk("restart.reload", int'(bus.timer_reload), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
